// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB first, repeated repeat_cnt times per start.
// Optional SEQGEN_GAP_EN inserts GAP_LEN idle cycles between repetitions.
module sequence_generator #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 'b1011,
    parameter int              CNT_W   = 8,
    parameter int              GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);
    localparam int             IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

    if (PAT_W < 2 || GAP_LEN < 1) begin : g_bad_param
        $error("sequence_generator: PAT_W must be >= 2 and GAP_LEN >= 1");
    end

`ifdef SEQGEN_GAP_EN
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
    localparam int               GAP_W   = $clog2(GAP_LEN + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_LEN - 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`else
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             x_q, x_d, xv_q, xv_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
`ifdef SEQGEN_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            IDLE: begin
                // A load in the same cycle as start is visible to the new frame.
                if (pat_load) pat_d = pat_in;
                if (start && repeat_cnt != '0) begin
                    state_d = SEND;
                    rep_d   = repeat_cnt;
                    idx_d   = IDX_MAX;
                end
            end
            SEND: begin
                if (idx_q == '0) begin
                    if (rep_q > CNT_W'(1)) begin
                        rep_d = rep_q - CNT_W'(1);
                        idx_d = IDX_MAX;
`ifdef SEQGEN_GAP_EN
                        state_d = GAP;
                        gap_d   = GAP_MAX;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
`ifdef SEQGEN_GAP_EN
            GAP: begin
                if (gap_q == '0) begin
                    state_d = SEND;
                    idx_d   = IDX_MAX;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        xv_d   = (state_d == SEND);
        x_d    = xv_d & pat_d[idx_d];
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= PATTERN;
            rep_q   <= '0;
            idx_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SEQGEN_GAP_EN
    always_ff @(posedge clk) begin
        if (!reset) gap_q <= '0;
        else        gap_q <= gap_d;
    end
`endif

    assign x       = x_q;
    assign x_valid = xv_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule
